// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM output stage: handshake FSM encoding,
// LED width and the duty saturation helper.
package led_pkg;

  localparam int LED_W = 4;

  // Pending-slot state: EMPTY accepts a nibble, PENDING waits for a period boundary.
  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Clamp a duty request to the full-on value (2**PWM_BITS).
  function automatic int unsigned sat_duty(input int unsigned req, input int unsigned full);
    return (req > full) ? full : req;
  endfunction

endpackage

// File: rtl/led_pwm_prescaler.sv
// Divides clk down to the PWM step rate: a free-running 0..CLK_DIV-1 counter
// whose last count is flagged as the step pulse.
module led_pwm_prescaler
  import led_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  output logic step
);

  // A one-bit counter still works for CLK_DIV=1: it sits at 0 and steps every cycle.
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count up to the last step position, then wrap to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign step = (cnt == LAST);

endmodule

// File: rtl/led_pwm_driver.sv
// LED output stage: accepts pattern nibbles through a one-deep pending slot,
// swaps pattern and duty only at PWM period boundaries, and dims each lit LED
// with a shared PWM compare.
// Build option LED_PWM_BREATHE_EN: replaces the programmable duty with a
// triangular per-period ramp; duty/duty_we are then ignored.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int PWM_BITS   = 4,
  parameter int DUTY_RESET = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LED_W-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PWM_BITS:0]  duty,
  input  logic               duty_we,
  output logic [LED_W-1:0]   led,
  output logic               period_tick
);

  localparam int FULL = 2 ** PWM_BITS;

  typedef logic [PWM_BITS:0] duty_t;

  localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;
  localparam duty_t               DUTY_FULL  = duty_t'(FULL);
  localparam duty_t               DUTY_INIT  = duty_t'(DUTY_RESET);

  logic                step;
  logic                wrap;
  logic                transfer;
  state_t              state;
  logic [LED_W-1:0]    pending;
  logic [LED_W-1:0]    active;
  logic [PWM_BITS-1:0] pwm_cnt;
  duty_t               duty_active;

  led_pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .step (step)
  );

  assign wrap     = step & (pwm_cnt == CNT_MAX);
  assign transfer = in_valid & in_ready;

  // PWM position within the period; wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (step) begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Flag the first cycle of each new period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
    end
  end

  // Pending-slot FSM: a nibble accepted while EMPTY is held until the next
  // boundary. A transfer coinciding with a boundary only fills the slot, so it
  // waits a full period before becoming visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
      pending  <= '0;
      active   <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (transfer) begin
            pending  <= in_data;
            state    <= ST_PENDING;
            in_ready <= 1'b0;
          end
        end
        ST_PENDING: begin
          if (wrap) begin
            active   <= pending;
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef LED_PWM_BREATHE_EN
  logic ramp_up;

  // Triangular brightness ramp, one step per period, bouncing at 0 and full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_active <= DUTY_INIT;
      ramp_up     <= 1'b1;
    end else if (wrap) begin
      if (ramp_up) begin
        if (duty_active >= DUTY_FULL) begin
          duty_active <= duty_active - 1'b1;
          ramp_up     <= 1'b0;
        end else begin
          duty_active <= duty_active + 1'b1;
        end
      end else begin
        if (duty_active == '0) begin
          duty_active <= duty_active + 1'b1;
          ramp_up     <= 1'b1;
        end else begin
          duty_active <= duty_active - 1'b1;
        end
      end
    end
  end
`else
  duty_t duty_shadow;

  // Capture a saturated duty request; it waits in the shadow until a boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_shadow <= DUTY_INIT;
    end else if (duty_we) begin
      duty_shadow <= duty_t'(sat_duty(32'(duty), FULL));
    end
  end

  // Promote the shadow at the boundary; a same-edge write lands a period later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_active <= DUTY_INIT;
    end else if (wrap) begin
      duty_active <= duty_shadow;
    end
  end
`endif

  // Registered LED drive: each lit bit is gated by the PWM compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= active & {LED_W{({1'b0, pwm_cnt} < duty_active)}};
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with CLK_DIV=2, PWM_BITS=2, DUTY_RESET=2
// (8-cycle period). Edge numbers count rising edges since reset release; a
// period boundary falls on every 8th edge, and led after edge n reflects the
// PWM position after edge n-1, i.e. ((n-1)/2)%4.
module tb_led_pwm_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data = 4'h0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] duty = 3'd0;
  logic       duty_we = 1'b0;
  logic [3:0] led;
  logic       period_tick;

  int total = 0;
  int bad   = 0;
  int edge_n;
  int xfer_cnt;

  always #5 clk = ~clk;

  led_pwm_driver #(
    .CLK_DIV    (2),
    .PWM_BITS   (2),
    .DUTY_RESET (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .duty        (duty),
    .duty_we     (duty_we),
    .led         (led),
    .period_tick (period_tick)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  // One line per accepted nibble.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= 0;
    end else if (in_valid && in_ready) begin
      xfer_cnt <= xfer_cnt + 1;
      $display("xfer edge=%0d data=%h", edge_n + 1, in_data);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the falling edge after rising edge k.
  task automatic wait_edge(input int k);
    while (edge_n < k) @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset
    repeat (2) @(negedge clk);
    check_val("por_led", led, 4'h0);
    check_val("por_ready", in_ready, 1'b1);
    check_val("por_tick", period_tick, 1'b0);

    // Pre-reset activity: load F, then leave 3 pending
    rst = 1'b0; in_data = 4'hF; in_valid = 1'b1;
    wait_edge(1);  in_valid = 1'b0;
    wait_edge(9);
    check_val("pre_led", led, 4'hF);
    in_data = 4'h3; in_valid = 1'b1;
    wait_edge(10); in_valid = 1'b0;
    check_val("pre_ready", in_ready, 1'b0);

    // Mid-run reset clears outputs without waiting for a clock edge
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst_led", led, 4'h0);
    check_val("mid_rst_ready", in_ready, 1'b1);
    check_val("mid_rst_tick", period_tick, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // First boundary eight edges after release; the lost nibble never shows
    wait_edge(7);  check_val("tick_early", period_tick, 1'b0);
    wait_edge(8);  check_val("tick_first", period_tick, 1'b1);
    wait_edge(9);
    check_val("tick_pulse_end", period_tick, 1'b0);
    check_val("lost_pending_led", led, 4'h0);
    check_val("idle_ready", in_ready, 1'b1);

    // Handshake: F accepted at edge 10, then 5 held under backpressure
    in_data = 4'hF; in_valid = 1'b1;
    wait_edge(10);
    check_val("ready_fall", in_ready, 1'b0);
    in_data = 4'h5;
    wait_edge(16);
    check_val("tick_16", period_tick, 1'b1);
    check_val("ready_rise", in_ready, 1'b1);
    for (int n = 17; n <= 24; n++) begin
      wait_edge(n);
      if (n == 17) begin
        check_val("ready_refill", in_ready, 1'b0);
        in_valid = 1'b0;
      end
      check_val($sformatf("led_F_e%0d", n), led, (n <= 20) ? 4'hF : 4'h0);
    end

    // 5 becomes active at edge 24; request duty 0 at edge 26
    wait_edge(25);
    check_val("led_5_on", led, 4'h5);
    check_val("ready_after_5", in_ready, 1'b1);
    duty = 3'd0; duty_we = 1'b1;
    wait_edge(26); duty_we = 1'b0;
    wait_edge(27); check_val("duty0_not_yet", led, 4'h5);
    wait_edge(29); check_val("led_5_off", led, 4'h0);
    wait_edge(33); check_val("duty0_a", led, 4'h0);
    wait_edge(34); check_val("duty0_b", led, 4'h0);

    // Request duty 7 (saturates to full) at edge 35
    duty = 3'd7; duty_we = 1'b1;
    wait_edge(35); duty_we = 1'b0;
    check_val("duty7_not_yet", led, 4'h0);
    wait_edge(41); check_val("full_a", led, 4'h5);
    wait_edge(47); check_val("full_b", led, 4'h5);

    // Transfer A and duty 1 on the boundary edge 48
    in_data = 4'hA; in_valid = 1'b1; duty = 3'd1; duty_we = 1'b1;
    wait_edge(48);
    in_valid = 1'b0; duty_we = 1'b0;
    check_val("full_c", led, 4'h5);
    check_val("tick_48", period_tick, 1'b1);
    check_val("sim_ready", in_ready, 1'b0);
    wait_edge(49); check_val("sim_hold_a", led, 4'h5);
    wait_edge(56);
    check_val("sim_hold_b", led, 4'h5);
    check_val("sim_ready_back", in_ready, 1'b1);
    wait_edge(57); check_val("sim_new_on", led, 4'hA);
    wait_edge(59); check_val("sim_new_off", led, 4'h0);

    check_val("xfer_count", xfer_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
